// File: rtl/alu_pkg.sv
// Shared opcode constants and flag bit positions for the ALU datapath.
package alu_pkg;

    localparam logic [7:0] OP_AND  = 8'h01;
    localparam logic [7:0] OP_OR   = 8'h02;
    localparam logic [7:0] OP_XOR  = 8'h03;
    localparam logic [7:0] OP_ADD  = 8'h05;
    localparam logic [7:0] OP_NOT  = 8'h07;
    localparam logic [7:0] OP_SUB  = 8'h09;
    localparam logic [7:0] OP_CMP  = 8'h0B;
    localparam logic [7:0] OP_MOV  = 8'h0D;
    localparam logic [7:0] OP_LSH  = 8'h84;
    localparam logic [7:0] OP_ASHU = 8'h86;

    localparam int FLAG_N = 4;
    localparam int FLAG_Z = 3;
    localparam int FLAG_F = 2;
    localparam int FLAG_L = 1;
    localparam int FLAG_C = 0;

    function automatic logic is_defined(input logic [7:0] op);
        case (op)
            OP_AND, OP_OR, OP_XOR, OP_ADD, OP_NOT,
            OP_SUB, OP_CMP, OP_MOV, OP_LSH, OP_ASHU:
                is_defined = 1'b1;
            default:
                is_defined = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/regfile16.sv
// 16x16 register file: two async read ports, one sync write port.
// Reset loads each register with its own index.
module regfile16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  ra,
    input  logic [3:0]  rb,
    input  logic [3:0]  wa,
    input  logic [15:0] wd,
    input  logic        we,
    output logic [15:0] rd_a,
    output logic [15:0] rd_b
);

    logic [15:0] regs [16];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                regs[i] <= 16'(i);
            end
        end else if (we) begin
            regs[wa] <= wd;
        end
    end

    assign rd_a = regs[ra];
    assign rd_b = regs[rb];

endmodule

// File: rtl/alu_data.sv
// ALU datapath: operand muxes, combinational ALU, flag register,
// and write-back into the register file at reg[rb].
module alu_data
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  ra,
    input  logic [3:0]  rb,
    input  logic        im_mux,
    input  logic        pc_mux,
    input  logic [15:0] pc,
    input  logic [15:0] immediate,
    input  logic [7:0]  OP,
    input  logic        regwrt,
    output logic [4:0]  flag,
    output logic [15:0] ALU_output
);

    logic [15:0] rd_a;
    logic [15:0] rd_b;
    logic [15:0] a;
    logic [15:0] b;
    logic [16:0] sum;
    logic [16:0] diff;
    logic [4:0]  amt;
    logic [15:0] shl;
    logic [15:0] lsr;
    logic [15:0] asr;
    logic        we;
    logic        flag_en;
    logic [4:0]  flag_nxt;

    assign a = pc_mux ? pc : rd_a;
    assign b = im_mux ? immediate : rd_b;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    // Negative counts become a 1..16 right-shift magnitude.
    assign amt = ~b[4:0] + 5'd1;
    assign shl = a << b[3:0];
    assign lsr = a >> amt;
    assign asr = 16'($signed(a) >>> amt);

    always_comb begin
        ALU_output = '0;
        case (OP)
            OP_AND:  ALU_output = a & b;
            OP_OR:   ALU_output = a | b;
            OP_XOR:  ALU_output = a ^ b;
            OP_ADD:  ALU_output = sum[15:0];
            OP_NOT:  ALU_output = ~a;
            OP_SUB:  ALU_output = diff[15:0];
            OP_CMP:  ALU_output = diff[15:0];
            OP_MOV:  ALU_output = a;
            OP_LSH:  ALU_output = b[4] ? lsr : shl;
            OP_ASHU: ALU_output = b[4] ? asr : shl;
            default: ALU_output = '0;
        endcase
    end

    always_comb begin
        flag_en  = 1'b0;
        flag_nxt = flag;
        if (OP == OP_ADD) begin
            flag_en          = 1'b1;
            flag_nxt[FLAG_C] = sum[16];
            flag_nxt[FLAG_L] = a < b;
            flag_nxt[FLAG_F] = (a[15] == b[15]) && (sum[15] != a[15]);
            flag_nxt[FLAG_Z] = sum[15:0] == 16'h0;
            flag_nxt[FLAG_N] = sum[15];
        end else if (OP == OP_SUB || OP == OP_CMP) begin
            flag_en          = 1'b1;
            flag_nxt[FLAG_C] = diff[16];
            flag_nxt[FLAG_L] = a < b;
            flag_nxt[FLAG_F] = (a[15] != b[15]) && (diff[15] != a[15]);
            flag_nxt[FLAG_Z] = diff[15:0] == 16'h0;
            flag_nxt[FLAG_N] = $signed(a) < $signed(b);
        end
    end

    assign we = regwrt && is_defined(OP) && (OP != OP_CMP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag <= '0;
        end else if (flag_en) begin
            flag <= flag_nxt;
        end
    end

    regfile16 u_regfile (
        .clk   (clk),
        .rst_n (rst_n),
        .ra    (ra),
        .rb    (rb),
        .wa    (rb),
        .wd    (ALU_output),
        .we    (we),
        .rd_a  (rd_a),
        .rd_b  (rd_b)
    );

endmodule

// File: tb/tb_alu_data.sv
// Directed-vector bench for alu_data.
module tb_alu_data;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [3:0]  ra = '0;
    logic [3:0]  rb = '0;
    logic        im_mux = 1'b0;
    logic        pc_mux = 1'b0;
    logic [15:0] pc = '0;
    logic [15:0] immediate = '0;
    logic [7:0]  OP = '0;
    logic        regwrt = 1'b0;
    logic [4:0]  flag;
    logic [15:0] ALU_output;

    int total = 0;
    int bad = 0;

    alu_data dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ra         (ra),
        .rb         (rb),
        .im_mux     (im_mux),
        .pc_mux     (pc_mux),
        .pc         (pc),
        .immediate  (immediate),
        .OP         (OP),
        .regwrt     (regwrt),
        .flag       (flag),
        .ALU_output (ALU_output)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic [7:0] op, input logic [3:0] a_i,
                         input logic [3:0] b_i, input logic pm,
                         input logic im, input logic [15:0] p,
                         input logic [15:0] imm, input logic wr);
        OP = op; ra = a_i; rb = b_i; pc_mux = pm; im_mux = im;
        pc = p; immediate = imm; regwrt = wr;
        #1;
    endtask

    task automatic test_reset;
        #1 rst_n = 1'b0;
        #1;
        total++;
        if (flag !== 5'h00) begin
            bad++;
            $display("FAIL reset_flag got=%h exp=00", flag);
        end
        for (int i = 0; i < 16; i++) begin
            drive(8'h0D, 4'(i), 4'd0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
            total++;
            if (ALU_output !== 16'(i)) begin
                bad++;
                $display("FAIL reset_reg%0d got=%h exp=%h",
                         i, ALU_output, 16'(i));
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(8'h05, 4'd0, 4'd0, 1'b1, 1'b1, 16'h0, 16'h1, 1'b0);
        total++;
        if (ALU_output !== 16'h0001) begin
            bad++;
            $display("FAIL add_pc_imm got=%h exp=0001", ALU_output);
        end
        drive(8'h05, 4'd0, 4'd0, 1'b0, 1'b1, 16'h0, 16'h1, 1'b0);
        total++;
        if (ALU_output !== 16'h0001) begin
            bad++;
            $display("FAIL add_reg_imm got=%h exp=0001", ALU_output);
        end
        drive(8'h09, 4'd2, 4'd1, 1'b0, 1'b0, 16'h0, 16'h1, 1'b0);
        total++;
        if (ALU_output !== 16'h0001) begin
            bad++;
            $display("FAIL sub_reg got=%h exp=0001", ALU_output);
        end
    endtask

    task automatic test_logic;
        drive(8'h02, 4'd2, 4'd4, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        total++;
        if (ALU_output !== 16'h0006) begin
            bad++;
            $display("FAIL or got=%h exp=0006", ALU_output);
        end
        drive(8'h07, 4'd2, 4'd4, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        total++;
        if (ALU_output !== 16'hFFFD) begin
            bad++;
            $display("FAIL not got=%h exp=FFFD", ALU_output);
        end
        drive(8'h01, 4'd7, 4'd3, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        total++;
        if (ALU_output !== 16'h0003) begin
            bad++;
            $display("FAIL and got=%h exp=0003", ALU_output);
        end
        drive(8'h84, 4'd2, 4'd1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        total++;
        if (ALU_output !== 16'h0004) begin
            bad++;
            $display("FAIL lsh_pos got=%h exp=0004", ALU_output);
        end
    endtask

    task automatic test_shift;
        @(negedge clk);
        drive(8'h0D, 4'd0, 4'd7, 1'b1, 1'b0, 16'hFFFF, 16'h0, 1'b1);
        @(posedge clk);
        #1;
        drive(8'h86, 4'd0, 4'd7, 1'b1, 1'b0, 16'h8000, 16'h0, 1'b0);
        total++;
        if (ALU_output !== 16'hC000) begin
            bad++;
            $display("FAIL ashu_m1 got=%h exp=C000", ALU_output);
        end
        drive(8'h84, 4'd0, 4'd7, 1'b1, 1'b0, 16'h8000, 16'h0, 1'b0);
        total++;
        if (ALU_output !== 16'h4000) begin
            bad++;
            $display("FAIL lsh_m1 got=%h exp=4000", ALU_output);
        end
        drive(8'h84, 4'd0, 4'd0, 1'b1, 1'b1, 16'h8000, 16'h0010, 1'b0);
        total++;
        if (ALU_output !== 16'h0000) begin
            bad++;
            $display("FAIL lsh_m16 got=%h exp=0000", ALU_output);
        end
        drive(8'h86, 4'd0, 4'd0, 1'b1, 1'b1, 16'h8000, 16'h0010, 1'b0);
        total++;
        if (ALU_output !== 16'hFFFF) begin
            bad++;
            $display("FAIL ashu_m16 got=%h exp=FFFF", ALU_output);
        end
        drive(8'h86, 4'd0, 4'd0, 1'b1, 1'b1, 16'h4000, 16'h0010, 1'b0);
        total++;
        if (ALU_output !== 16'h0000) begin
            bad++;
            $display("FAIL ashu_m16_pos got=%h exp=0000", ALU_output);
        end
        drive(8'h84, 4'd0, 4'd0, 1'b1, 1'b1, 16'h0001, 16'h000F, 1'b0);
        total++;
        if (ALU_output !== 16'h8000) begin
            bad++;
            $display("FAIL lsh_p15 got=%h exp=8000", ALU_output);
        end
    endtask

    task automatic test_add_carry;
        @(negedge clk);
        drive(8'h05, 4'd0, 4'd0, 1'b1, 1'b1, 16'hFFFF, 16'h0001, 1'b0);
        total++;
        if (ALU_output !== 16'h0000) begin
            bad++;
            $display("FAIL add_wrap got=%h exp=0000", ALU_output);
        end
        @(posedge clk);
        #1;
        total++;
        if (flag !== 5'b01001) begin
            bad++;
            $display("FAIL add_flags got=%b exp=01001", flag);
        end
    endtask

    task automatic test_cmp;
        @(negedge clk);
        drive(8'h0B, 4'd10, 4'd6, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
        total++;
        if (ALU_output !== 16'h0004) begin
            bad++;
            $display("FAIL cmp_out got=%h exp=0004", ALU_output);
        end
        @(posedge clk);
        #1;
        total++;
        if (flag !== 5'b00000) begin
            bad++;
            $display("FAIL cmp_flags got=%b exp=00000", flag);
        end
        drive(8'h0D, 4'd6, 4'd0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        total++;
        if (ALU_output !== 16'h0006) begin
            bad++;
            $display("FAIL cmp_nowrite got=%h exp=0006", ALU_output);
        end
    endtask

    task automatic test_sub_ovf;
        @(negedge clk);
        drive(8'h09, 4'd0, 4'd0, 1'b1, 1'b1, 16'h8000, 16'h0001, 1'b0);
        total++;
        if (ALU_output !== 16'h7FFF) begin
            bad++;
            $display("FAIL sub_ovf_out got=%h exp=7FFF", ALU_output);
        end
        @(posedge clk);
        #1;
        total++;
        if (flag !== 5'b10100) begin
            bad++;
            $display("FAIL sub_ovf_flags got=%b exp=10100", flag);
        end
        @(negedge clk);
        drive(8'h09, 4'd0, 4'd0, 1'b1, 1'b1, 16'h0003, 16'h0005, 1'b0);
        @(posedge clk);
        #1;
        total++;
        if (flag !== 5'b10011) begin
            bad++;
            $display("FAIL sub_borrow_flags got=%b exp=10011", flag);
        end
        @(negedge clk);
        drive(8'h09, 4'd0, 4'd0, 1'b1, 1'b1, 16'h8000, 16'h0001, 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic test_undef;
        @(negedge clk);
        drive(8'hFF, 4'd0, 4'd3, 1'b1, 1'b1, 16'h1234, 16'h5678, 1'b1);
        total++;
        if (ALU_output !== 16'h0000) begin
            bad++;
            $display("FAIL undef_out got=%h exp=0000", ALU_output);
        end
        @(posedge clk);
        #1;
        total++;
        if (flag !== 5'b10100) begin
            bad++;
            $display("FAIL undef_flags got=%b exp=10100", flag);
        end
        drive(8'h0D, 4'd3, 4'd0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        total++;
        if (ALU_output !== 16'h0003) begin
            bad++;
            $display("FAIL undef_nowrite got=%h exp=0003", ALU_output);
        end
    endtask

    task automatic test_no_bypass;
        @(negedge clk);
        drive(8'h03, 4'd0, 4'd5, 1'b1, 1'b0, 16'hAB00, 16'h0, 1'b1);
        total++;
        if (ALU_output !== 16'hAB05) begin
            bad++;
            $display("FAIL xor_pre got=%h exp=AB05", ALU_output);
        end
        @(posedge clk);
        #1;
        regwrt = 1'b0;
        #1;
        total++;
        if (ALU_output !== 16'h0005) begin
            bad++;
            $display("FAIL xor_post got=%h exp=0005", ALU_output);
        end
        total++;
        if (flag !== 5'b10100) begin
            bad++;
            $display("FAIL xor_flags got=%b exp=10100", flag);
        end
    endtask

    task automatic test_mov_reset;
        @(negedge clk);
        drive(8'h0D, 4'd10, 4'd1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
        @(posedge clk);
        #1;
        drive(8'h0D, 4'd1, 4'd9, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        total++;
        if (ALU_output !== 16'h000A) begin
            bad++;
            $display("FAIL mov_write got=%h exp=000A", ALU_output);
        end
        drive(8'h0D, 4'd10, 4'd1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        ra = 4'd1;
        #1;
        total++;
        if (ALU_output !== 16'h0001) begin
            bad++;
            $display("FAIL reset_async_reg got=%h exp=0001", ALU_output);
        end
        total++;
        if (flag !== 5'h00) begin
            bad++;
            $display("FAIL reset_async_flag got=%b exp=00000", flag);
        end
        ra = 4'd10;
        @(posedge clk);
        #1;
        ra = 4'd1;
        #1;
        total++;
        if (ALU_output !== 16'h0001) begin
            bad++;
            $display("FAIL reset_override got=%h exp=0001", ALU_output);
        end
        @(negedge clk);
        regwrt = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_logic();
        test_shift();
        test_add_carry();
        test_cmp();
        test_sub_ovf();
        test_undef();
        test_no_bypass();
        test_mov_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
